// File: rtl/i2s_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_pkg
//  Description : Shared I2S constants and channel encoding for the transmit
//                and receive slaves.
//  Revision    : 1.0  initial release
// ============================================================================
package i2s_pkg;

    localparam int I2S_WIDTH = 16;

    localparam logic LRCK_LEFT  = 1'b0;
    localparam logic LRCK_RIGHT = 1'b1;

    // Channel encoding tracks the lrck level directly so it can be cast from it.
    typedef enum logic {
        CH_LEFT  = LRCK_LEFT,
        CH_RIGHT = LRCK_RIGHT
    } i2s_ch_e;

    // Width of a counter that must hold values 0..max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2s_rx_slave_if.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_rx_slave_if
//  Description : Serial input pins and parallel stereo output of the I2S
//                receive slave.
//  Revision    : 1.0  initial release
// ============================================================================
interface i2s_rx_slave_if
    import i2s_pkg::*;
#(
    parameter int WIDTH = I2S_WIDTH
);

    logic             lrck;
    logic             sdata;
    logic [WIDTH-1:0] l_data;
    logic [WIDTH-1:0] r_data;
    logic             sample_valid;
    logic             frame_err;

    modport slave (
        input  lrck,
        input  sdata,
        output l_data,
        output r_data,
        output sample_valid,
        output frame_err
    );

    modport master (
        output lrck,
        output sdata,
        input  l_data,
        input  r_data,
        input  sample_valid,
        input  frame_err
    );

endinterface
`default_nettype wire

// File: rtl/i2s_rx_slave.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_rx_slave
//  Description : I2S receive slave; deserialises codec sdata on bclk and
//                emits one left/right pair per frame with a valid strobe.
//  Revision    : 1.0  initial release
// ============================================================================
module i2s_rx_slave
    import i2s_pkg::*;
#(
    parameter int WIDTH    = I2S_WIDTH,
    parameter int MIN_SLOT = WIDTH
) (
    input  logic            bclk,
    input  logic            rst,
    i2s_rx_slave_if.slave   bus
);

    localparam int CNT_W  = cnt_width(WIDTH);
    localparam int SLOT_W = cnt_width(2 * WIDTH + 1);

    localparam logic [CNT_W-1:0]  C_CNT_FULL = CNT_W'(WIDTH);
    localparam logic [SLOT_W-1:0] C_SLOT_MAX = SLOT_W'(2 * WIDTH + 1);
    localparam logic [SLOT_W-1:0] C_SLOT_MIN = SLOT_W'(MIN_SLOT);

    logic [WIDTH-2:0]  r_sreg;
    logic [CNT_W-1:0]  r_cnt;
    logic [SLOT_W-1:0] r_slot;
    logic              r_lrck_q;
    logic              r_active;
    logic              r_l_got;
    logic [WIDTH-1:0]  r_l_hold;
    i2s_ch_e           r_ch;
    logic [WIDTH-1:0]  r_l_data;
    logic [WIDTH-1:0]  r_r_data;
    logic              r_valid;
    logic              r_err;

    logic              w_edge;
    logic              w_shift;
    logic [WIDTH-1:0]  w_word;
    logic [CNT_W-1:0]  w_cnt_next;
    logic              w_done;
    logic              w_bad;

    always_comb begin
        w_edge     = (bus.lrck != r_lrck_q);
        w_shift    = r_active && (r_cnt < C_CNT_FULL);
        w_word     = {r_sreg, bus.sdata};
        w_cnt_next = w_shift ? (r_cnt + CNT_W'(1)) : r_cnt;
        w_done     = w_shift && (w_cnt_next == C_CNT_FULL);
        // A slot is malformed if it was too short or its word never filled.
        w_bad      = r_active && ((r_slot < C_SLOT_MIN) || (w_cnt_next < C_CNT_FULL));
    end

    always_ff @(posedge bclk) begin
        if (rst) begin
            r_sreg   <= '0;
            r_cnt    <= '0;
            r_slot   <= '0;
            r_lrck_q <= 1'b0;
            r_active <= 1'b0;
            r_l_got  <= 1'b0;
            r_l_hold <= '0;
            r_ch     <= CH_LEFT;
            r_l_data <= '0;
            r_r_data <= '0;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_lrck_q <= bus.lrck;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;

            if (w_shift) begin
                r_sreg <= w_word[WIDTH-2:0];
                r_cnt  <= w_cnt_next;
            end

            if (w_done) begin
                if (r_ch == CH_LEFT) begin
                    r_l_hold <= w_word;
                    r_l_got  <= 1'b1;
                end else if (r_l_got) begin
                    r_l_data <= r_l_hold;
                    r_r_data <= w_word;
                    r_valid  <= 1'b1;
                    r_l_got  <= 1'b0;
                end
            end

            // The edge posedge counts as the first bclk of the new slot.
            if (w_edge) begin
                r_slot <= SLOT_W'(1);
            end else if (r_slot != C_SLOT_MAX) begin
                r_slot <= r_slot + SLOT_W'(1);
            end

            // Placed last so the edge overrides the count and pairing above.
            if (w_edge) begin
                if (w_bad) begin
                    r_err   <= 1'b1;
                    r_l_got <= 1'b0;
                end
                r_cnt    <= '0;
                r_ch     <= i2s_ch_e'(bus.lrck);
                r_active <= 1'b1;
            end
        end
    end

    assign bus.l_data       = r_l_data;
    assign bus.r_data       = r_r_data;
    assign bus.sample_valid = r_valid;
    assign bus.frame_err    = r_err;

endmodule
`default_nettype wire
